dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter sharing the single-port data memory `dmem` (64 x 32-bit words, combinational read, write on rising `clk`) between port 0 (CPU load/store unit) and port 1 (DMA/debug loader). The block sequences one word access per grant with round-robin fairness, registers read data and a response pulse per port, and blocks out-of-range writes. It sits between the requesters and the memory's `we`/`a`/`wd`/`rd` pins.

## Interface
- `DEPTH`, 64: number of memory words; the valid word index is `a[31:2] < DEPTH`.

- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `req0` / `req1`  in  1  access request (level), held until that port's `ack`
- `we0` / `we1`  in  1  1 = write, 0 = read; stable while `req` is high
- `a0` / `a1`  in  32  byte address; bits [1:0] are ignored
- `wd0` / `wd1`  in  32  write data
- `lock0` / `lock1`  in  1  hold ownership across accesses (see Configuration)
- `gnt0` / `gnt1`  out  1  port owns the memory this cycle
- `ack0` / `ack1`  out  1  one-cycle completion pulse
- `err0` / `err1`  out  1  out-of-range pulse, coincident with `ack`
- `rd0` / `rd1`  out  32  registered read data, valid from `ack` until that port's next `ack`
- `mem_we`  out  1  to `dmem.we`
- `mem_a`  out  32  to `dmem.a`
- `mem_wd`  out  32  to `dmem.wd`
- `mem_rd`  in  32  from `dmem.rd`

## Operation
- States: IDLE, SERVE. `owner` register (1 bit), `prio` pointer (1 bit).
- IDLE: an eligible request means `reqN`=1 and `ackN`=0 in this cycle. With none, stay in IDLE. With one, go to SERVE with `owner` = that port. With both, `owner` = `prio`.
- SERVE: `gnt[owner]`=1. `mem_a`, `mem_wd` = owner's `a`, `wd`. `mem_we` = owner's `we` AND in_range. SERVE always lasts one cycle and is followed by IDLE.
- At the edge ending SERVE:
  - `rd[owner]` <= `mem_rd` on a read, or 0 when out of range. Unchanged on a write.
  - `ack[owner]` <= 1.
  - `err[owner]` <= !in_range.
  - `prio` <= ~owner.
- in_range = (`a[31:2]` < `DEPTH`). Out of range: no write, and `mem_a` is driven as 0.
- In IDLE: `mem_we`=0, `mem_a`=0, `mem_wd`=0, both `gnt`=0.
- After reset, `prio` = 0, so the CPU wins the first tie.
- A port still holding `req` in the cycle after its `ack` starts a new transaction.

## Timing
- Reset values: `gnt*`=0, `ack*`=0, `err*`=0, `rd*`=0, `mem_we`=0, `mem_a`=0, `mem_wd`=0, state=IDLE, `prio`=0, `owner`=0, lock flag=0.
- Latency: `req` first high in cycle 0 with the arbiter IDLE -> `gnt` in cycle 1 -> `ack`, `rd`, `err` in cycle 2. The write commits at the edge ending cycle 1.
- Throughput: at most one access every 2 cycles (SERVE then IDLE).
- A losing request waits one extra SERVE+IDLE pair.
- Reset asserted during SERVE: state goes to IDLE immediately and `mem_we` drops combinationally, so no write occurs and no `ack` is produced.
- `mem_*` outputs are combinational from state, `owner` and the owner's inputs. All other outputs are registered.

## Configuration
- `DMEM_ARB_LOCK_EN` defined:
  - If `lock[owner]`=1 during SERVE, a `locked` flag is set at the edge ending SERVE and `prio` is not advanced.
  - While `locked`, IDLE grants only the lock holder. The other port waits.
  - `locked` clears at the end of a SERVE with `lock[owner]`=0, or in IDLE when the holder has `req`=0 and `lock`=0.
- Not defined: `lock0`/`lock1` are ignored, there is no `locked` register, and arbitration is pure round-robin.

## Test plan
- Port 0 writes `a0`=0x8, `wd0`=0x1234 -> `mem_we`=1 in the `gnt0` cycle only; `ack0` 1 cycle later with `err0`=0. A following port 0 read of 0x8 -> `rd0`=0x1234 at `ack0`.
- `req0` and `req1` rise together, both reads, after reset -> port 0 is granted first, then port 1 (cycles 1 and 3); `ack0` in cycle 2, `ack1` in cycle 4.
- Both ports hold `req` continuously for 8 transactions -> grants alternate 0,1,0,1…; neither port gets two consecutive grants while the other waits.
- Port 1 writes `a1`=0x100 (word 64, out of range) -> `mem_we`=0 and `mem_a`=0 in SERVE; `ack1`=`err1`=1; memory is unchanged.
- Assert `rst_n`=0 mid-SERVE of a port 0 write to 0x4 -> no write to word 1, `ack0` stays 0, all outputs return to reset values.
- With `DMEM_ARB_LOCK_EN`: port 1 performs 3 accesses with `lock1`=1 while `req0` is held -> all 3 go to port 1; port 0 is granted after port 1's access with `lock1`=0.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: one requester port (request, address/data, lock, grant/response) of dmem_arbiter
interface dmem_arbiter_if;
    logic        req;
    logic        we;
    logic        lock;
    logic [31:0] a;
    logic [31:0] wd;
    logic        gnt;
    logic        ack;
    logic        err;
    logic [31:0] rd;
    modport master (output req, we, lock, a, wd, input gnt, ack, err, rd);
    modport slave  (input req, we, lock, a, wd, output gnt, ack, err, rd);
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin two-port arbiter for a single-port data memory; DMEM_ARB_LOCK_EN enables ownership locking
module dmem_arbiter #(
    parameter int DEPTH = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    dmem_arbiter_if.slave port0,
    dmem_arbiter_if.slave port1,
    output logic          mem_we_o,
    output logic [31:0]   mem_a_o,
    output logic [31:0]   mem_wd_o,
    input  logic [31:0]   mem_rd_i
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SERVE = 1'b1;

    logic [0:0]  state_q, state_d;
    logic        owner_q, owner_d;
    logic        prio_q, prio_d;
    logic [1:0]  gnt_q, gnt_d;
    logic [1:0]  ack_q, ack_d;
    logic [1:0]  err_q, err_d;
    logic [31:0] rd0_q, rd0_d;
    logic [31:0] rd1_q, rd1_d;
    logic [1:0]  req, elig;
    logic        serve, sel_we, in_range;
    logic [31:0] sel_a, sel_wd;

    assign req      = {port1.req, port0.req};
    assign serve    = state_q == SERVE;
    assign sel_we   = owner_q ? port1.we : port0.we;
    assign sel_a    = owner_q ? port1.a : port0.a;
    assign sel_wd   = owner_q ? port1.wd : port0.wd;
    assign in_range = {2'b00, sel_a[31:2]} < 32'(DEPTH);

    // memory pins follow the owner only while serving; out-of-range accesses never reach the array
    assign mem_we_o = serve && sel_we && in_range;
    assign mem_a_o  = (serve && in_range) ? sel_a : '0;
    assign mem_wd_o = serve ? sel_wd : '0;

    assign port0.gnt = gnt_q[0];
    assign port1.gnt = gnt_q[1];
    assign port0.ack = ack_q[0];
    assign port1.ack = ack_q[1];
    assign port0.err = err_q[0];
    assign port1.err = err_q[1];
    assign port0.rd  = rd0_q;
    assign port1.rd  = rd1_q;

`ifdef DMEM_ARB_LOCK_EN
    logic       locked_q, locked_d;
    logic [1:0] lock;
    assign lock = {port1.lock, port0.lock};
    // a port is eligible unless it is being acked now; while locked only the holder may win
    assign elig = (req & ~ack_q) & (locked_q ? (owner_q ? 2'b10 : 2'b01) : 2'b11);
`else
    logic unused_lock;
    assign unused_lock = port0.lock ^ port1.lock;
    // a port is eligible unless it is being acked now
    assign elig = req & ~ack_q;
`endif

    // next state: pick an owner in IDLE, complete its single access at the end of SERVE
    always_comb begin
        state_d = IDLE;
        owner_d = owner_q;
        prio_d  = prio_q;
        gnt_d   = '0;
        ack_d   = '0;
        err_d   = '0;
        rd0_d   = rd0_q;
        rd1_d   = rd1_q;
`ifdef DMEM_ARB_LOCK_EN
        locked_d = locked_q;
`endif
        if (!serve) begin
            if (|elig) begin
                state_d = SERVE;
                owner_d = (elig == 2'b11) ? prio_q : elig[1];
                gnt_d   = owner_d ? 2'b10 : 2'b01;
            end
`ifdef DMEM_ARB_LOCK_EN
            if (locked_q && !req[owner_q] && !lock[owner_q]) locked_d = 1'b0;
`endif
        end else begin
            ack_d[owner_q] = 1'b1;
            err_d[owner_q] = !in_range;
            if (!sel_we && owner_q)  rd1_d = in_range ? mem_rd_i : '0;
            if (!sel_we && !owner_q) rd0_d = in_range ? mem_rd_i : '0;
            prio_d = ~owner_q;
`ifdef DMEM_ARB_LOCK_EN
            locked_d = lock[owner_q];
            if (lock[owner_q]) prio_d = prio_q;
`endif
        end
    end

    // state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            prio_q  <= 1'b0;
            gnt_q   <= '0;
            ack_q   <= '0;
            err_q   <= '0;
            rd0_q   <= '0;
            rd1_q   <= '0;
`ifdef DMEM_ARB_LOCK_EN
            locked_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rd0_q   <= rd0_d;
            rd1_q   <= rd1_d;
`ifdef DMEM_ARB_LOCK_EN
            locked_q <= locked_d;
`endif
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: vector table plus corner sequences for dmem_arbiter, with an ack-driven scoreboard
module tb_dmem_arbiter;
    typedef struct {
        logic [31:0] rd;
        logic        err;
    } exp_t;

    typedef struct {
        int          p;
        logic        we;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_we;
    logic [31:0] mem_a, mem_wd, mem_rd;
    logic [31:0] mem [64] = '{default: 32'h0};
    int          tests = 0;
    int          fails = 0;
    exp_t        q0[$];
    exp_t        q1[$];
    vec_t        vt [13];

    dmem_arbiter_if i0();
    dmem_arbiter_if i1();

    dmem_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .port0    (i0),
        .port1    (i1),
        .mem_we_o (mem_we),
        .mem_a_o  (mem_a),
        .mem_wd_o (mem_wd),
        .mem_rd_i (mem_rd)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_we) mem[mem_a[7:2]] <= mem_wd;
    assign mem_rd = mem[mem_a[7:2]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int p, input logic [31:0] rd, input logic err);
        exp_t e;
        e.rd = rd;
        e.err = err;
        if (p == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (i0.ack) begin
            if (q0.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL ack0_unexpected: got ack0=1 expected no ack at %0t", $time);
            end else begin
                e = q0.pop_front();
                chk("rd0", i0.rd, e.rd);
                chk("err0", 32'(i0.err), 32'(e.err));
            end
        end
        if (i1.ack) begin
            if (q1.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL ack1_unexpected: got ack1=1 expected no ack at %0t", $time);
            end else begin
                e = q1.pop_front();
                chk("rd1", i1.rd, e.rd);
                chk("err1", 32'(i1.err), 32'(e.err));
            end
        end
    endtask

    task automatic set_port(input int p, input logic r, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input logic l);
        if (p == 0) begin
            i0.req = r; i0.we = w; i0.a = a; i0.wd = d; i0.lock = l;
        end else begin
            i1.req = r; i1.we = w; i1.a = a; i1.wd = d; i1.lock = l;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        tick();
        chk("rst_gnt", 32'({i1.gnt, i0.gnt}), 32'h0);
        chk("rst_ack", 32'({i1.ack, i0.ack}), 32'h0);
        chk("rst_err", 32'({i1.err, i0.err}), 32'h0);
        chk("rst_rd0", i0.rd, 32'h0);
        chk("rst_rd1", i1.rd, 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        chk("rst_mem_a", mem_a, 32'h0);
        chk("rst_mem_wd", mem_wd, 32'h0);
        q0.delete();
        q1.delete();
        rst_n = 1'b1;
    endtask

    task automatic access(input vec_t v);
        int         gt;
        bit         got;
        logic [1:0] g, k;
        push(v.p, v.rd, v.err);
        set_port(v.p, 1'b1, v.we, v.a, v.wd, 1'b0);
        got = 0;
        gt = -1;
        for (int n = 0; n < 20 && !got; n++) begin
            tick();
            g = {i1.gnt, i0.gnt};
            k = {i1.ack, i0.ack};
            if (g[v.p]) begin
                gt = n;
                chk("bus_we", 32'(mem_we), 32'(v.we && !v.err));
                chk("bus_a", mem_a, v.err ? 32'h0 : v.a);
                chk("bus_wd", mem_wd, v.wd);
            end else if (g == 2'b00) begin
                chk("idle_we", 32'(mem_we), 32'h0);
                chk("idle_a", mem_a, 32'h0);
            end
            if (k[v.p]) begin
                got = 1;
                chk("ack_lat", 32'(n - gt), 32'h1);
            end
        end
        if (!got) begin
            tests++;
            fails++;
            $display("FAIL access_timeout: got no ack on port %0d expected ack within 20 cycles", v.p);
        end
        set_port(v.p, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    initial begin
        vt[0]  = '{0, 1'b1, 32'h8,        32'h1234, 32'h0,      1'b0};
        vt[1]  = '{0, 1'b0, 32'h8,        32'h0,    32'h1234,   1'b0};
        vt[2]  = '{1, 1'b1, 32'h100,      32'hDEAD, 32'h0,      1'b1};
        vt[3]  = '{1, 1'b0, 32'h0,        32'h0,    32'h0,      1'b0};
        vt[4]  = '{1, 1'b1, 32'hFC,       32'hCAFE, 32'h0,      1'b0};
        vt[5]  = '{0, 1'b0, 32'hFC,       32'h0,    32'hCAFE,   1'b0};
        vt[6]  = '{0, 1'b0, 32'h103,      32'h0,    32'h0,      1'b1};
        vt[7]  = '{1, 1'b0, 32'hFF,       32'h0,    32'hCAFE,   1'b0};
        vt[8]  = '{0, 1'b1, 32'h4,        32'h55,   32'h0,      1'b0};
        vt[9]  = '{0, 1'b0, 32'h4,        32'h0,    32'h55,     1'b0};
        vt[10] = '{0, 1'b0, 32'hFFFFFFFC, 32'h0,    32'h0,      1'b1};
        vt[11] = '{1, 1'b1, 32'h8,        32'hBEEF, 32'hCAFE,   1'b0};
        vt[12] = '{0, 1'b0, 32'h8,        32'h0,    32'hBEEF,   1'b0};
        set_port(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        set_port(1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        do_reset();

        for (int i = 0; i < 13; i++) access(vt[i]);
        chk("oor_nowrite", mem[0], 32'h0);

        // simultaneous requests after reset: port 0 wins the first tie
        do_reset();
        set_port(0, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0);
        set_port(1, 1'b1, 1'b0, 32'hFC, 32'h0, 1'b0);
        push(0, 32'hBEEF, 1'b0);
        push(1, 32'hCAFE, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("tie_gnt", 32'({i1.gnt, i0.gnt}), k == 1 ? 32'h1 : k == 3 ? 32'h2 : 32'h0);
            chk("tie_ack", 32'({i1.ack, i0.ack}), k == 2 ? 32'h1 : k == 4 ? 32'h2 : 32'h0);
            if (i0.ack) i0.req = 1'b0;
            if (i1.ack) i1.req = 1'b0;
        end
        tick();

        // both ports requesting continuously: grants alternate 0,1,0,1...
        set_port(0, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0);
        set_port(1, 1'b1, 1'b0, 32'h8, 32'h0, 1'b0);
        for (int j = 0; j < 4; j++) begin
            push(0, 32'h55, 1'b0);
            push(1, 32'hBEEF, 1'b0);
        end
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("rr_gnt", 32'({i1.gnt, i0.gnt}),
                (k % 2) ? (((k / 2) % 2) ? 32'h2 : 32'h1) : 32'h0);
            chk("rr_ack", 32'({i1.ack, i0.ack}),
                (k % 2) ? 32'h0 : (((k / 2 - 1) % 2) ? 32'h2 : 32'h1));
            if (k == 16) begin
                i0.req = 1'b0;
                i1.req = 1'b0;
            end
        end
        tick();

        // reset asserted mid-SERVE of a write: nothing is written or acked
        set_port(0, 1'b1, 1'b1, 32'h4, 32'h999, 1'b0);
        tick();
        chk("mid_gnt", 32'(i0.gnt), 32'h1);
        chk("mid_we", 32'(mem_we), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we", 32'(mem_we), 32'h0);
        chk("mid_rst_gnt", 32'(i0.gnt), 32'h0);
        set_port(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        do_reset();
        chk("mid_nowrite", mem[1], 32'h55);
        access('{0, 1'b0, 32'h4, 32'h0, 32'h55, 1'b0});

`ifdef DMEM_ARB_LOCK_EN
        begin
            int n1 = 0;
            bit seen0 = 0;
            bit done = 0;
            set_port(1, 1'b1, 1'b0, 32'hFC, 32'h0, 1'b1);
            for (int j = 0; j < 3; j++) push(1, 32'hCAFE, 1'b0);
            tick();
            chk("lock_first_gnt", 32'(i1.gnt), 32'h1);
            set_port(0, 1'b1, 1'b0, 32'h4, 32'h0, 1'b0);
            push(0, 32'h55, 1'b0);
            for (int n = 0; n < 40 && !done; n++) begin
                tick();
                if (i0.gnt && !seen0) begin
                    seen0 = 1;
                    chk("lock_hold", 32'(n1), 32'h3);
                end
                if (i1.ack) begin
                    n1++;
                    if (n1 == 2) i1.lock = 1'b0;
                    if (n1 == 3) i1.req = 1'b0;
                end
                if (i0.ack) begin
                    done = 1;
                    i0.req = 1'b0;
                end
            end
            chk("lock_done", 32'(done), 32'h1);
        end
`endif

        tick();
        chk("sb_drain", 32'(q0.size() + q1.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
